seq_detect_sched: RTL and testbench

Scheduler that feeds parallel words, one bit at a time, into the 1010/0101 overlapping Mealy sequence detector. It accepts a word on a valid/ready handshake, clears the detector, and presents the bits MSB-first at a programmable bit rate. It samples the detector's Mealy output on each bit step, then reports the match count and the index of the first match. It replaces the free-running divided clock: the detector runs on `clk` and advances only when `bit_en` is high.

---
 rtl/seq_detect_sched_if.sv | 25 ++
 rtl/seq_detect_sched.sv | 119 +++++++++++
 tb/tb_seq_detect_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_sched_if.sv
// Word-in / result-out bundle of the sequence-detector scheduler.
// The master side supplies words and consumes results; the scheduler is the slave.
interface seq_detect_sched_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) ();
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             match_valid;
  logic [CNT_W-1:0] match_count;
  logic             match_any;
  logic [IDX_W-1:0] first_idx;

  modport master (
    output word_in, word_valid,
    input  word_ready, match_valid, match_count, match_any, first_idx
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, match_valid, match_count, match_any, first_idx
  );
endinterface

// File: rtl/seq_detect_sched.sv
// Serialises a parallel word MSB-first into an external 1010/0101 Mealy detector
// at a programmable bit rate, then reports match count and first-match index.
module seq_detect_sched #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned IDX_W    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_sched_if.slave  bus,
  output logic               det_clr,
  output logic               bit_out,
  output logic               bit_en,
  input  logic               det_in
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   shreg_q, shreg_n;
  logic [TICK_W-1:0]  tick_q,  tick_n;
  logic [IDX_W-1:0]   idx_q,   idx_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic               any_q,   any_n;
  logic [IDX_W-1:0]   first_q, first_n;
  logic               ready_q, valid_q;

  // Next-state and datapath update; bit_en (registered) marks the step cycle
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    tick_n  = tick_q;
    idx_n   = idx_q;
    count_n = count_q;
    any_n   = any_q;
    first_n = first_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.word_valid && ready_q) begin
          shreg_n = bus.word_in;
          count_n = '0;
          any_n   = 1'b0;
          first_n = '0;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tick_n  = '0;
        idx_n   = '0;
        state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_en) begin
          if (det_in) begin
            if (count_q != {CNT_W{1'b1}}) count_n = count_q + 1'b1;
            if (!any_q) begin
              first_n = idx_q;
              any_n   = 1'b1;
            end
          end
          shreg_n = {shreg_q[WIDTH-2:0], 1'b0};
          idx_n   = idx_q + 1'b1;
          tick_n  = '0;
          if (idx_q == IDX_W'(WIDTH - 1)) state_n = ST_REPORT;
        end else begin
          tick_n = tick_q + 1'b1;
        end
      end
      ST_REPORT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are decoded from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      tick_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      any_q   <= 1'b0;
      first_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      det_clr <= 1'b0;
      bit_out <= 1'b0;
      bit_en  <= 1'b0;
    end else begin
      state_q <= state_n;
      shreg_q <= shreg_n;
      tick_q  <= tick_n;
      idx_q   <= idx_n;
      count_q <= count_n;
      any_q   <= any_n;
      first_q <= first_n;
      ready_q <= (state_n == ST_IDLE);
      valid_q <= (state_n == ST_REPORT);
      det_clr <= (state_n == ST_LOAD);
      bit_out <= (state_n == ST_SHIFT) && shreg_n[WIDTH-1];
      bit_en  <= (state_n == ST_SHIFT) && (tick_n == TICK_W'(TICK_DIV - 1));
    end
  end

  assign bus.word_ready  = ready_q;
  assign bus.match_valid = valid_q;
  assign bus.match_count = count_q;
  assign bus.match_any   = any_q;
  assign bus.first_idx   = first_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched with a behavioural 1010/0101 overlapping
// Mealy detector attached to each scheduler instance.
module tb_seq_detect_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Default-parameter instance
  seq_detect_sched_if #(.WIDTH(8), .CNT_W(4)) bus ();
  logic det_clr, bit_out, bit_en, det_in;
  seq_detect_sched #(.WIDTH(8), .TICK_DIV(4), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .det_clr(det_clr), .bit_out(bit_out), .bit_en(bit_en), .det_in(det_in)
  );

  // Saturation instance: 2-bit counter, one clk per bit
  seq_detect_sched_if #(.WIDTH(8), .CNT_W(2)) bus2 ();
  logic det_clr2, bit_out2, bit_en2, det_in2;
  seq_detect_sched #(.WIDTH(8), .TICK_DIV(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(bus2.slave),
    .det_clr(det_clr2), .bit_out(bit_out2), .bit_en(bit_en2), .det_in(det_in2)
  );

  // Detector models: 3-bit history plus fill count since the last clear
  logic [2:0] h1, h2;
  logic [1:0] n1, n2;
  always @(posedge clk) begin
    if (reset || det_clr) begin h1 <= '0; n1 <= '0; end
    else if (bit_en) begin h1 <= {h1[1:0], bit_out}; if (n1 != 2'd3) n1 <= n1 + 2'd1; end
    if (reset || det_clr2) begin h2 <= '0; n2 <= '0; end
    else if (bit_en2) begin h2 <= {h2[1:0], bit_out2}; if (n2 != 2'd3) n2 <= n2 + 2'd1; end
  end
  assign det_in  = (n1 == 2'd3) && ({h1, bit_out}  == 4'b1010 || {h1, bit_out}  == 4'b0101);
  assign det_in2 = (n2 == 2'd3) && ({h2, bit_out2} == 4'b1010 || {h2, bit_out2} == 4'b0101);

  int         n_clr, n_en, gap_bad, rdy_bad, res_lat;
  logic [3:0] res_count;
  logic       res_any;
  logic [2:0] res_first;

  // Send one word on the default instance and collect its result and step trace
  task automatic do_word(input logic [7:0] w, input int pulse_at);
    int t_acc, guard, last_en;
    n_clr = 0; n_en = 0; gap_bad = 0; rdy_bad = 0; last_en = -1;
    @(negedge clk);
    guard = 0;
    while (!bus.word_ready && guard < 100) begin @(negedge clk); guard++; end
    bus.word_in = w; bus.word_valid = 1'b1; t_acc = cyc;
    @(negedge clk);
    guard = 0;
    while (!bus.match_valid && guard < 200) begin
      bus.word_valid = (guard == pulse_at);
      bus.word_in    = (guard == pulse_at) ? 8'hFF : 8'h00;
      if (det_clr) n_clr++;
      if (bit_en) begin
        if (last_en >= 0 && (cyc - last_en) != 4) gap_bad++;
        last_en = cyc; n_en++;
      end
      if (bus.word_ready) rdy_bad++;
      @(negedge clk); guard++;
    end
    bus.word_valid = 1'b0;
    res_lat   = bus.match_valid ? (cyc - t_acc) : -1;
    res_count = bus.match_count;
    res_any   = bus.match_any;
    res_first = bus.first_idx;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.word_valid = 1'b0; bus.word_in = '0;
    bus2.word_valid = 1'b0; bus2.word_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.word_ready, det_clr, bit_out, bit_en, bus.match_valid, bus.match_count,
         bus.match_any, bus.first_idx} !== '0) begin
      failures++; $display("FAIL reset_outputs got=nonzero exp=0");
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.word_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%0b exp=1", bus.word_ready);
    end
  endtask

  task automatic test_overlap();
    do_word(8'b1010_1010, -1);
    checks++; if (res_lat !== 34) begin failures++; $display("FAIL overlap_latency got=%0d exp=34", res_lat); end
    checks++; if (res_count !== 4'd5) begin failures++; $display("FAIL overlap_count got=%0d exp=5", res_count); end
    checks++; if (res_any !== 1'b1) begin failures++; $display("FAIL overlap_any got=%0b exp=1", res_any); end
    checks++; if (res_first !== 3'd3) begin failures++; $display("FAIL overlap_first got=%0d exp=3", res_first); end
  endtask

  task automatic test_two_matches();
    do_word(8'b0101_0000, -1);
    checks++; if (res_count !== 4'd2) begin failures++; $display("FAIL two_count got=%0d exp=2", res_count); end
    checks++; if (res_first !== 3'd3) begin failures++; $display("FAIL two_first got=%0d exp=3", res_first); end
    checks++; if (n_clr !== 1) begin failures++; $display("FAIL two_det_clr got=%0d exp=1", n_clr); end
    checks++; if (n_en !== 8) begin failures++; $display("FAIL two_bit_en_count got=%0d exp=8", n_en); end
    checks++; if (gap_bad !== 0) begin failures++; $display("FAIL two_bit_en_gap got=%0d exp=0", gap_bad); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.match_count !== 4'd2 || bus.first_idx !== 3'd3 || bus.match_valid !== 1'b0) begin
      failures++; $display("FAIL two_hold got=%0d exp=2", bus.match_count);
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, guard;
    @(negedge clk);
    guard = 0;
    while (!bus.word_ready && guard < 100) begin @(negedge clk); guard++; end
    bus.word_in = 8'h00; bus.word_valid = 1'b1; t1 = cyc;
    @(negedge clk);
    bus.word_in = 8'hFF;
    guard = 0;
    while (!bus.match_valid && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (bus.match_valid !== 1'b1 || bus.match_count !== 4'd0 || bus.match_any !== 1'b0 || bus.first_idx !== 3'd0) begin
      failures++; $display("FAIL b2b_word0 got=%0d exp=0", bus.match_count);
    end
    guard = 0;
    @(negedge clk);
    while (!bus.word_ready && guard < 100) begin @(negedge clk); guard++; end
    t2 = cyc;
    checks++; if ((t2 - t1) !== 35) begin failures++; $display("FAIL b2b_accept got=%0d exp=35", t2 - t1); end
    @(negedge clk);
    bus.word_valid = 1'b0; bus.word_in = 8'h00;
    guard = 0;
    while (!bus.match_valid && guard < 200) begin @(negedge clk); guard++; end
    checks++; if ((cyc - t2) !== 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", cyc - t2); end
    checks++;
    if (bus.match_count !== 4'd0 || bus.match_any !== 1'b0 || bus.first_idx !== 3'd0) begin
      failures++; $display("FAIL b2b_word1 got=%0d exp=0", bus.match_count);
    end
  endtask

  task automatic test_handshake_ignore();
    do_word(8'b1010_0000, 12);
    checks++; if (res_count !== 4'd1) begin failures++; $display("FAIL hs_count got=%0d exp=1", res_count); end
    checks++; if (res_first !== 3'd3 || res_any !== 1'b1) begin failures++; $display("FAIL hs_first got=%0d exp=3", res_first); end
    checks++; if (rdy_bad !== 0) begin failures++; $display("FAIL hs_ready_low got=%0d exp=0", rdy_bad); end
    checks++; if (res_lat !== 34) begin failures++; $display("FAIL hs_latency got=%0d exp=34", res_lat); end
    @(negedge clk);
    checks++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL hs_ready_after got=%0b exp=1", bus.word_ready); end
  endtask

  task automatic test_reset_mid();
    int mv, guard;
    mv = 0;
    @(negedge clk);
    guard = 0;
    while (!bus.word_ready && guard < 100) begin @(negedge clk); guard++; end
    bus.word_in = 8'hAA; bus.word_valid = 1'b1;
    @(negedge clk);
    bus.word_valid = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.word_ready, det_clr, bit_out, bit_en, bus.match_valid, bus.match_count,
         bus.match_any, bus.first_idx} !== '0) begin
      failures++; $display("FAIL midreset_outputs got=nonzero exp=0");
    end
    repeat (2) begin @(negedge clk); if (bus.match_valid) mv++; end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.word_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%0b exp=1", bus.word_ready); end
    repeat (40) begin if (bus.match_valid || bit_en) mv++; @(negedge clk); end
    checks++; if (mv !== 0) begin failures++; $display("FAIL midreset_abort got=%0d exp=0", mv); end
  endtask

  task automatic test_saturation();
    int t, guard;
    @(negedge clk);
    guard = 0;
    while (!bus2.word_ready && guard < 100) begin @(negedge clk); guard++; end
    bus2.word_in = 8'b1010_1010; bus2.word_valid = 1'b1; t = cyc;
    @(negedge clk);
    bus2.word_valid = 1'b0;
    guard = 0;
    while (!bus2.match_valid && guard < 100) begin @(negedge clk); guard++; end
    checks++; if ((cyc - t) !== 10) begin failures++; $display("FAIL sat_latency got=%0d exp=10", cyc - t); end
    checks++; if (bus2.match_count !== 2'd3) begin failures++; $display("FAIL sat_count got=%0d exp=3", bus2.match_count); end
    checks++; if (bus2.first_idx !== 3'd3 || bus2.match_any !== 1'b1) begin failures++; $display("FAIL sat_first got=%0d exp=3", bus2.first_idx); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_two_matches();
    test_back_to_back();
    test_handshake_ignore();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
